// File: rtl/pc_seq_unit.sv
// Program-counter sequencer.
// Produces the next fetch PC from, in priority order:
//   1. an exception vector
//   2. a live branch, jump or register-jump redirect
//   3. a redirect buffered during a stall
//   4. the sequential successor
module pc_seq_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      STEP     = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0]      EXC_PC   = 32'h0000_1180
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             Stall,
    input  logic             Exc_Req,
    input  logic             Branch_Taken,
    input  logic [WIDTH-1:0] Branch_Target,
    input  logic             Jump,
    input  logic [WIDTH-1:0] Jump_Target,
    input  logic             Jr,
    input  logic [WIDTH-1:0] Jr_Target,
    output logic [WIDTH-1:0] Pc_Out,
    output logic [WIDTH-1:0] Pc_Add_Out,
    output logic             Pc_Valid,
    output logic             Redirect_Pending
);

    localparam logic [WIDTH-1:0] EXC_VEC = WIDTH'(EXC_PC);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic             req_c;
    logic [WIDTH-1:0] win_tgt_c;
    logic [WIDTH-1:0] pc_inc_c;

    // Non-exception redirect arbitration: branch > jump > register jump.
    always_comb begin
        req_c     = Branch_Taken | Jump | Jr;
        win_tgt_c = Jr_Target;
        if (Branch_Taken) begin
            win_tgt_c = Branch_Target;
        end else if (Jump) begin
            win_tgt_c = Jump_Target;
        end
    end

    // Sequential successor, wrapping modulo 2^WIDTH.
    always_comb begin
        pc_inc_c = pc_q + STEP_W;
    end

    // Next-state selection for the PC, valid flag and the one-entry redirect buffer.
    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (!valid_q) begin
            // First edge out of reset only raises valid; PC stays at RESET_PC.
            valid_d = 1'b1;
        end else if (Exc_Req) begin
            pc_d   = EXC_VEC;
            pend_d = 1'b0;
        end else if (!Stall) begin
            pend_d = 1'b0;
            if (req_c) begin
                // A live request is younger than anything buffered.
                pc_d = win_tgt_c;
            end else if (pend_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = pc_inc_c;
            end
        end else if (req_c) begin
            // Stalled redirect is parked; a newer one overwrites it.
            pend_d     = 1'b1;
            pend_tgt_d = win_tgt_c;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign Pc_Out           = pc_q;
    assign Pc_Add_Out       = pc_inc_c;
    assign Pc_Valid         = valid_q;
    assign Redirect_Pending = pend_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: a 32-bit word-stepping instance and an 8-bit byte-stepping
// instance share stimulus and are compared against a priority-rule model every cycle.
module tb_pc_seq_unit;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b1;
    logic        Stall = 1'b0;
    logic        Exc_Req = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Target = '0;
    logic        Jump = 1'b0;
    logic [31:0] Jump_Target = '0;
    logic        Jr = 1'b0;
    logic [31:0] Jr_Target = '0;

    logic [31:0] Pc_Out, Pc_Add_Out;
    logic        Pc_Valid, Redirect_Pending;
    logic [7:0]  pc8_out, pc8_add;
    logic        pc8_valid, pc8_pend;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pc_seq_unit #(.WIDTH(32), .STEP(1), .RESET_PC(32'h0), .EXC_PC(32'h0000_1180)) dut32 (
        .Clk(Clk), .Reset_N(Reset_N), .Stall(Stall), .Exc_Req(Exc_Req),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Jump(Jump), .Jump_Target(Jump_Target), .Jr(Jr), .Jr_Target(Jr_Target),
        .Pc_Out(Pc_Out), .Pc_Add_Out(Pc_Add_Out), .Pc_Valid(Pc_Valid),
        .Redirect_Pending(Redirect_Pending)
    );

    pc_seq_unit #(.WIDTH(8), .STEP(4), .RESET_PC(8'hF8), .EXC_PC(32'h0000_1180)) dut8 (
        .Clk(Clk), .Reset_N(Reset_N), .Stall(Stall), .Exc_Req(Exc_Req),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target[7:0]),
        .Jump(Jump), .Jump_Target(Jump_Target[7:0]), .Jr(Jr), .Jr_Target(Jr_Target[7:0]),
        .Pc_Out(pc8_out), .Pc_Add_Out(pc8_add), .Pc_Valid(pc8_valid),
        .Redirect_Pending(pc8_pend)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = 32-bit/step 1, index 1 = 8-bit/step 4.
    logic [31:0] m_pc [2];
    logic [31:0] m_tgt[2];
    bit          m_valid[2];
    bit          m_pend [2];
    logic [31:0] m_mask[2]  = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_step[2]  = '{32'd1, 32'd4};
    logic [31:0] m_rst [2]  = '{32'h0, 32'hF8};
    logic [31:0] m_exc [2]  = '{32'h1180, 32'h80};

    always @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i] = m_rst[i]; m_tgt[i] = '0; m_valid[i] = 0; m_pend[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit          req;
                logic [31:0] t;
                req = Branch_Taken || Jump || Jr;
                t = Branch_Taken ? Branch_Target : (Jump ? Jump_Target : Jr_Target);
                t = t & m_mask[i];
                if (!m_valid[i]) m_valid[i] = 1;
                else if (Exc_Req) begin m_pc[i] = m_exc[i]; m_pend[i] = 0; end
                else if (!Stall && req) begin m_pc[i] = t; m_pend[i] = 0; end
                else if (!Stall && m_pend[i]) begin m_pc[i] = m_tgt[i]; m_pend[i] = 0; end
                else if (!Stall) m_pc[i] = (m_pc[i] + m_step[i]) & m_mask[i];
                else if (req) begin m_tgt[i] = t; m_pend[i] = 1; end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        check("m32_pc", Pc_Out, m_pc[0]);
        check("m32_add", Pc_Add_Out, (m_pc[0] + m_step[0]) & m_mask[0]);
        check("m32_valid", 32'(Pc_Valid), 32'(m_valid[0]));
        check("m32_pend", 32'(Redirect_Pending), 32'(m_pend[0]));
        check("m8_pc", 32'(pc8_out), m_pc[1]);
        check("m8_add", 32'(pc8_add), (m_pc[1] + m_step[1]) & m_mask[1]);
        check("m8_valid", 32'(pc8_valid), 32'(m_valid[1]));
        check("m8_pend", 32'(pc8_pend), 32'(m_pend[1]));
    end

    // Wait for next falling edge and check the 32-bit instance against literals.
    task automatic tick(input logic [31:0] pc, input logic v, input logic p);
        @(negedge Clk);
        check("lit_pc", Pc_Out, pc);
        check("lit_add", Pc_Add_Out, pc + 32'd1);
        check("lit_valid", 32'(Pc_Valid), 32'(v));
        check("lit_pend", 32'(Redirect_Pending), 32'(p));
    endtask

    task automatic set_in(input logic st, input logic ex,
                          input logic bt, input logic [31:0] btgt,
                          input logic j, input logic [31:0] jt,
                          input logic r, input logic [31:0] rt);
        #1;
        Stall = st; Exc_Req = ex;
        Branch_Taken = bt; Branch_Target = btgt;
        Jump = j; Jump_Target = jt;
        Jr = r; Jr_Target = rt;
    endtask

    initial begin
        #1 Reset_N = 1'b0;
        // Reset state
        tick(32'h0, 1'b0, 1'b0);
        check("lit8_rst_pc", 32'(pc8_out), 32'hF8);
        check("lit8_rst_add", 32'(pc8_add), 32'hFC);
        #1 Reset_N = 1'b1;
        // Release: valid after edge 1, then sequential
        tick(32'h0, 1'b1, 1'b0);
        check("lit8_e1", 32'(pc8_out), 32'hF8);
        tick(32'h1, 1'b1, 1'b0);
        check("lit8_fc", 32'(pc8_out), 32'hFC);
        check("lit8_fc_add", 32'(pc8_add), 32'h00);
        tick(32'h2, 1'b1, 1'b0);
        check("lit8_wrap", 32'(pc8_out), 32'h00);
        tick(32'h3, 1'b1, 1'b0);
        // Branch beats jump
        set_in(0, 0, 0, 0, 1, 32'h10, 0, 0);
        tick(32'h10, 1, 0);
        set_in(0, 0, 1, 32'h40, 1, 32'h80, 0, 0);
        tick(32'h40, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h41, 1, 0);
        // Jump buffered during a 3-cycle stall
        set_in(0, 0, 0, 0, 1, 32'h20, 0, 0);
        tick(32'h20, 1, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h20, 1, 0);
        set_in(1, 0, 0, 0, 1, 32'h100, 0, 0);
        tick(32'h20, 1, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h20, 1, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h100, 1, 0);
        tick(32'h101, 1, 0);
        // Exception during stall discards buffered Jr
        set_in(0, 0, 0, 0, 1, 32'h55, 0, 0);
        tick(32'h55, 1, 0);
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h300);
        tick(32'h55, 1, 1);
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        tick(32'h1180, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h1181, 1, 0);
        // Async reset mid-cycle with a buffered redirect
        set_in(1, 0, 0, 0, 0, 0, 1, 32'h700);
        tick(32'h1181, 1, 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #1 Reset_N = 1'b0;
        #1;
        check("lit_async_pc", Pc_Out, 32'h0);
        check("lit_async_valid", 32'(Pc_Valid), 32'h0);
        check("lit_async_pend", 32'(Redirect_Pending), 32'h0);
        #1 Reset_N = 1'b1;
        tick(32'h0, 1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h1, 1, 0);
        tick(32'h2, 1, 0);

        // Randomized phase with occasional reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge Clk);
            #1;
            if (!Reset_N) Reset_N = 1'b1;
            else if ($urandom_range(0, 99) == 0) Reset_N = 1'b0;
            Stall         = ($urandom_range(0, 2) == 0);
            Exc_Req       = ($urandom_range(0, 15) == 0);
            Branch_Taken  = ($urandom_range(0, 5) == 0);
            Jump          = ($urandom_range(0, 5) == 0);
            Jr            = ($urandom_range(0, 5) == 0);
            Branch_Target = $urandom;
            Jump_Target   = $urandom;
            Jr_Target     = $urandom;
        end
        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
